// File: rtl/l2_wbb_pkg.sv
// l2_wbb_pkg: shared types and constants for the L2 writeback buffer.
// Latency: n/a (types only).
// Backpressure: n/a.
package l2_wbb_pkg;

    localparam int LINE_W      = 256;
    localparam int ADDR_W      = 32;
    localparam int OFFSET_BITS = 5;   // byte offset within a line; always zero in line addresses

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wbb_state_t;

endpackage

// File: rtl/l2_wbb_match.sv
// l2_wbb_match: youngest-first address matcher over the circular entry array.
// Latency: combinational.
// Backpressure: none.
// Ports: valid/addrs = entry state, head_idx = oldest slot, probe = address to find,
//        hit = any valid match, onehot = slot of the youngest match (zero when no hit).
module l2_wbb_match
    import l2_wbb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int S_ADDR = ADDR_W,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]  valid,
    input  logic [S_ADDR-1:0] addrs [DEPTH],
    input  logic [IDX_W-1:0]  head_idx,
    input  logic [S_ADDR-1:0] probe,
    output logic              hit,
    output logic [DEPTH-1:0]  onehot
);

    logic [IDX_W-1:0] idx;

    // Walk from the oldest slot toward the tail; a later match overrides an
    // earlier one, so the surviving index is the youngest matching entry.
    always_comb begin
        hit    = 1'b0;
        onehot = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_idx + IDX_W'(k);
            if (valid[idx] && (addrs[idx] == probe)) begin
                hit    = 1'b1;
                onehot = '0;
                onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_writeback_buffer.sv
// l2_writeback_buffer: FIFO of dirty L2 victims drained one line per memory write;
//   coalesces re-evictions of a buffered line and serves miss probes from buffered data.
// Latency: enqueue into empty buffer -> pmem_write high 2 cycles later (no drain_block).
// Backpressure: enq_ready low only when full and enq_addr does not coalesce.
// Ports: enq_* = victim input, lkp_* = miss probe (combinational), pmem_* = memory write,
//        drain_block = hold off new drains, empty = no buffered lines.
// Optional: define L2_WBB_PERF_EN to add perf_drains / perf_coalesce / perf_full_stall.
module l2_writeback_buffer
    import l2_wbb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int S_LINE = LINE_W,
    parameter int S_ADDR = ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [S_ADDR-1:0] enq_addr,
    input  logic [S_LINE-1:0] enq_data,
    input  logic [S_ADDR-1:0] lkp_addr,
    output logic              lkp_hit,
    output logic [S_LINE-1:0] lkp_data,
    input  logic              drain_block,
    output logic              pmem_write,
    output logic [S_ADDR-1:0] pmem_address,
    output logic [S_LINE-1:0] pmem_wdata,
    input  logic              pmem_resp,
    output logic              empty
`ifdef L2_WBB_PERF_EN
    ,
    output logic [31:0]       perf_drains,
    output logic [31:0]       perf_coalesce,
    output logic [31:0]       perf_full_stall
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  head_q, tail_q, count;
    logic [DEPTH-1:0]  valid_q, coal_valid;
    logic [S_ADDR-1:0] addr_q [DEPTH];
    logic [S_LINE-1:0] data_q [DEPTH];
    wbb_state_t        state_q, state_d;

    logic [IDX_W-1:0]  head_idx, tail_idx;
    logic              full;
    logic              coal_hit;
    logic [DEPTH-1:0]  coal_onehot, lkp_onehot;
    logic              enq_fire, do_coal, do_alloc;
    logic              drain_start, drain_done, head_fwd;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign count    = tail_q - head_q;
    assign full     = (count == PTR_W'(DEPTH));
    assign empty    = (count == '0);

    // The in-flight head has its data captured already; it must not absorb
    // a coalesce, so a re-eviction of that address gets a fresh entry.
    always_comb begin
        coal_valid = valid_q;
        if (state_q == WRITE) begin
            coal_valid[head_idx] = 1'b0;
        end
    end

    l2_wbb_match #(.DEPTH(DEPTH), .S_ADDR(S_ADDR)) u_coal_match (
        .valid    (coal_valid),
        .addrs    (addr_q),
        .head_idx (head_idx),
        .probe    (enq_addr),
        .hit      (coal_hit),
        .onehot   (coal_onehot)
    );

    l2_wbb_match #(.DEPTH(DEPTH), .S_ADDR(S_ADDR)) u_lkp_match (
        .valid    (valid_q),
        .addrs    (addr_q),
        .head_idx (head_idx),
        .probe    (lkp_addr),
        .hit      (lkp_hit),
        .onehot   (lkp_onehot)
    );

    always_comb begin
        lkp_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (lkp_onehot[i]) begin
                lkp_data = data_q[i];
            end
        end
    end

    assign enq_ready   = !full || coal_hit;
    assign enq_fire    = enq_valid && enq_ready;
    assign do_coal     = enq_fire && coal_hit;
    assign do_alloc    = enq_fire && !coal_hit;
    assign drain_start = (state_q == IDLE) && !empty && !drain_block;
    assign drain_done  = (state_q == WRITE) && pmem_resp;
    // A coalesce into the head on the very cycle it is captured must reach
    // memory, otherwise the newer data would be lost when the head retires.
    assign head_fwd    = do_coal && coal_onehot[head_idx];
    assign pmem_write  = (state_q == WRITE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (drain_start) state_d = WRITE;
            WRITE:   if (drain_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            valid_q      <= '0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            state_q <= state_d;
            if (drain_start) begin
                pmem_address <= addr_q[head_idx];
                pmem_wdata   <= head_fwd ? enq_data : data_q[head_idx];
            end
            // Alloc slot never equals the in-flight head slot: not full implies tail != head.
            if (do_alloc) begin
                valid_q[tail_idx] <= 1'b1;
                tail_q            <= tail_q + 1'b1;
            end
            if (drain_done) begin
                valid_q[head_idx] <= 1'b0;
                head_q            <= head_q + 1'b1;
            end
        end
    end

    // Payload storage is qualified by valid_q and needs no reset.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            addr_q[tail_idx] <= enq_addr;
            data_q[tail_idx] <= enq_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (do_coal && coal_onehot[i]) begin
                data_q[i] <= enq_data;
            end
        end
    end

`ifdef L2_WBB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_drains     <= '0;
            perf_coalesce   <= '0;
            perf_full_stall <= '0;
        end else begin
            if (drain_done && (perf_drains != '1))
                perf_drains <= perf_drains + 32'd1;
            if (do_coal && (perf_coalesce != '1))
                perf_coalesce <= perf_coalesce + 32'd1;
            if (enq_valid && !enq_ready && (perf_full_stall != '1))
                perf_full_stall <= perf_full_stall + 32'd1;
        end
    end
`endif

endmodule
